// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking lane controller.
// Default timings derive from the 12 MHz system clock.
package parking_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      OPEN_IN  = 2'd1,
      OPEN_OUT = 2'd2,
      GUARD    = 2'd3
   } lane_state_t;

   typedef enum logic {
      DIR_IN  = 1'b0,
      DIR_OUT = 1'b1
   } dir_t;

   localparam int CLK_FREQ     = 12000000;
   localparam int DEF_CAPACITY = 7;
   localparam int DEF_CNT_W    = 3;
   localparam int DEF_TIMEOUT  = CLK_FREQ * 10;
   localparam int DEF_GUARD    = CLK_FREQ / 2;

endpackage

// File: rtl/lane_timer.sv
// Clearable up-counter with terminal-count compare; one instance serves both
// the open-barrier timeout and the closed-barrier guard interval.
module lane_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic [W-1:0] tc_val_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = clr_i ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/lane_arbiter.sv
// Shared parking-lane arbiter: grants entry or exit, round-robin on ties.
// Optional LANE_ARB_STATS_EN adds saturating deny/timeout event counters.
module lane_arbiter
   import parking_pkg::*;
#(
   parameter int CAPACITY    = DEF_CAPACITY,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT,
   parameter int GUARD_CYC   = DEF_GUARD
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_in,
   input  logic             req_out,
   input  logic             car_in_done,
   input  logic             car_out_done,
   input  logic [CNT_W-1:0] occupancy,
   output logic             gate_open,
   output logic             grant_in,
   output logic             grant_out,
   output logic             full_deny,
   output logic             timeout_p,
   output logic             proto_err
`ifdef LANE_ARB_STATS_EN
   ,
   output logic [15:0]      deny_cnt,
   output logic [15:0]      timeout_cnt
`endif
);

   localparam int TMR_MAX = (TIMEOUT_CYC > GUARD_CYC) ? TIMEOUT_CYC : GUARD_CYC;
   localparam int TW      = $clog2(TMR_MAX + 1);
   localparam logic [TW-1:0]    TO_TC  = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0]    GD_TC  = TW'((GUARD_CYC == 0) ? 0 : GUARD_CYC - 1);
   localparam logic [CNT_W-1:0] CAP_V  = CNT_W'(CAPACITY);
   localparam lane_state_t      END_ST = (GUARD_CYC == 0) ? IDLE : GUARD;

   lane_state_t state_q, state_d;
   dir_t        last_dir_q, last_dir_d;
   logic        gate_open_q, gate_open_d;
   logic        grant_in_q, grant_in_d;
   logic        grant_out_q, grant_out_d;
   logic        full_deny_q, full_deny_d;
   logic        timeout_p_q, timeout_p_d;
   logic        proto_err_q, proto_err_d;
   logic        elig_in, elig_out;
   logic        tmr_clr, tmr_tc;
   logic [TW-1:0] tmr_tc_val;

   assign tmr_clr    = (state_q == IDLE) || (state_d != state_q);
   assign tmr_tc_val = (state_q == GUARD) ? GD_TC : TO_TC;

   lane_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (tmr_clr),
      .tc_val_i (tmr_tc_val),
      .tc_o     (tmr_tc)
   );

   always_comb begin
      state_d     = state_q;
      last_dir_d  = last_dir_q;
      proto_err_d = proto_err_q;
      timeout_p_d = 1'b0;
      elig_in     = req_in && (occupancy < CAP_V);
      elig_out    = req_out && (occupancy != '0);

      unique case (state_q)
         IDLE: begin
            if (car_in_done || car_out_done) proto_err_d = 1'b1;
            if (elig_in && elig_out)
               state_d = (last_dir_q == DIR_OUT) ? OPEN_IN : OPEN_OUT;
            else if (elig_in)
               state_d = OPEN_IN;
            else if (elig_out)
               state_d = OPEN_OUT;
         end
         // A matching done on the terminal cycle wins over the timeout.
         OPEN_IN: begin
            if (car_out_done) proto_err_d = 1'b1;
            if (car_in_done || tmr_tc) begin
               state_d     = END_ST;
               last_dir_d  = DIR_IN;
               timeout_p_d = !car_in_done;
            end
         end
         OPEN_OUT: begin
            if (car_in_done) proto_err_d = 1'b1;
            if (car_out_done || tmr_tc) begin
               state_d     = END_ST;
               last_dir_d  = DIR_OUT;
               timeout_p_d = !car_out_done;
            end
         end
         GUARD: begin
            if (car_in_done || car_out_done) proto_err_d = 1'b1;
            if (tmr_tc) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      grant_in_d  = (state_d == OPEN_IN);
      grant_out_d = (state_d == OPEN_OUT);
      gate_open_d = grant_in_d || grant_out_d;
      full_deny_d = (state_q == IDLE) && (state_d == IDLE) && req_in && (occupancy == CAP_V);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_dir_q  <= DIR_OUT;
         gate_open_q <= 1'b0;
         grant_in_q  <= 1'b0;
         grant_out_q <= 1'b0;
         full_deny_q <= 1'b0;
         timeout_p_q <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_dir_q  <= last_dir_d;
         gate_open_q <= gate_open_d;
         grant_in_q  <= grant_in_d;
         grant_out_q <= grant_out_d;
         full_deny_q <= full_deny_d;
         timeout_p_q <= timeout_p_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign gate_open = gate_open_q;
   assign grant_in  = grant_in_q;
   assign grant_out = grant_out_q;
   assign full_deny = full_deny_q;
   assign timeout_p = timeout_p_q;
   assign proto_err = proto_err_q;

`ifdef LANE_ARB_STATS_EN
   logic [15:0] deny_cnt_q, deny_cnt_d;
   logic [15:0] timeout_cnt_q, timeout_cnt_d;

   always_comb begin
      deny_cnt_d    = deny_cnt_q;
      timeout_cnt_d = timeout_cnt_q;
      if (full_deny_d && !full_deny_q && (deny_cnt_q != '1))
         deny_cnt_d = deny_cnt_q + 16'd1;
      if (timeout_p_d && (timeout_cnt_q != '1))
         timeout_cnt_d = timeout_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deny_cnt_q    <= '0;
         timeout_cnt_q <= '0;
      end else begin
         deny_cnt_q    <= deny_cnt_d;
         timeout_cnt_q <= timeout_cnt_d;
      end
   end

   assign deny_cnt    = deny_cnt_q;
   assign timeout_cnt = timeout_cnt_q;
`else
   // Statistics counters not built.
`endif

endmodule

// File: tb/tb_lane_arbiter.sv
// Self-checking bench for lane_arbiter (TIMEOUT_CYC=20, GUARD_CYC=4, CAPACITY=7).
// Grant directions are predicted into a scoreboard and checked when the gate opens.
module tb_lane_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req_in, req_out, car_in_done, car_out_done;
   logic [2:0] occupancy;
   logic       gate_open, grant_in, grant_out, full_deny, timeout_p, proto_err;

   typedef struct {
      logic gi;
      logic go;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   logic prev_gate = 1'b0;

   lane_arbiter #(
      .CAPACITY    (7),
      .CNT_W       (3),
      .TIMEOUT_CYC (20),
      .GUARD_CYC   (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_in       (req_in),
      .req_out      (req_out),
      .car_in_done  (car_in_done),
      .car_out_done (car_out_done),
      .occupancy    (occupancy),
      .gate_open    (gate_open),
      .grant_in     (grant_in),
      .grant_out    (grant_out),
      .full_deny    (full_deny),
      .timeout_p    (timeout_p),
      .proto_err    (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic gi, input logic go);
      exp_t e;
      e.gi = gi;
      e.go = go;
      sb_q.push_back(e);
   endtask

   task automatic pulse_in_done();
      car_in_done = 1'b1;
      tick();
      car_in_done = 1'b0;
   endtask

   task automatic pulse_out_done();
      car_out_done = 1'b1;
      tick();
      car_out_done = 1'b0;
   endtask

   task automatic wait_gate(input string tag, input int max, output int n);
      n = 0;
      while (gate_open !== 1'b1 && n < max) begin
         tick();
         n++;
      end
      check_eq(tag, gate_open, 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      check_eq("rst_gate_open", gate_open, 0);
      check_eq("rst_grants", {grant_in, grant_out}, 0);
      check_eq("rst_flags", {full_deny, timeout_p, proto_err}, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Scoreboard consumer: every opening of the gate must match a predicted grant.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_gate = 1'b0;
      end else begin
         if (gate_open === 1'b1 && prev_gate !== 1'b1) begin
            if (sb_q.size() == 0) begin
               check_eq("sb_unexpected_grant", 1, 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check_eq("sb_grant_dir", {grant_in, grant_out}, {e.gi, e.go});
            end
         end
         prev_gate = gate_open;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      req_in = 1'b0; req_out = 1'b0;
      car_in_done = 1'b0; car_out_done = 1'b0;
      occupancy = 3'd0;

      // 1: reset values, then single-cycle grant latency
      #3;
      check_eq("t1_rst_outputs", {gate_open, grant_in, grant_out, full_deny, timeout_p, proto_err}, 0);
      #4;
      rst_n = 1'b1;
      req_in = 1'b1; occupancy = 3'd3;
      push_exp(1, 0);
      tick();
      check_eq("t1_grant_in", grant_in, 1);
      check_eq("t1_gate_open", gate_open, 1);

      // 2: done at open cycle 5, guard length
      req_in = 1'b0;
      repeat (5) tick();
      check_eq("t2_still_open", gate_open, 1);
      pulse_in_done();
      check_eq("t2_gate_closed", {gate_open, grant_in}, 0);
      check_eq("t2_no_timeout", timeout_p, 0);
      req_in = 1'b1;
      push_exp(1, 0);
      repeat (4) tick();
      check_eq("t2_guard_closed", gate_open, 0);
      wait_gate("t2_regrant", 10, n);
      check_eq("t2_guard_len", n, 1);
      req_in = 1'b0;
      pulse_in_done();
      repeat (5) tick();

      // 3: round robin from reset, entry wins the first tie
      do_reset();
      req_in = 1'b1; req_out = 1'b1; occupancy = 3'd3;
      push_exp(1, 0);
      tick();
      check_eq("t3_first_in", {grant_in, grant_out}, 2'b10);
      repeat (2) tick();
      push_exp(0, 1);
      pulse_in_done();
      wait_gate("t3_open_out", 10, n);
      check_eq("t3_second_out", {grant_in, grant_out}, 2'b01);
      push_exp(1, 0);
      pulse_out_done();
      wait_gate("t3_open_in", 10, n);
      check_eq("t3_third_in", {grant_in, grant_out}, 2'b10);
      req_in = 1'b0; req_out = 1'b0;
      pulse_in_done();
      repeat (5) tick();

      // 4: full and empty refusals, boundary occupancy
      occupancy = 3'd7; req_in = 1'b1;
      tick();
      check_eq("t4_full_deny", full_deny, 1);
      tick();
      check_eq("t4_full_no_grant", {gate_open, grant_in}, 0);
      req_in = 1'b0;
      tick();
      check_eq("t4_deny_drop", full_deny, 0);
      occupancy = 3'd0; req_out = 1'b1;
      repeat (2) tick();
      check_eq("t4_empty_no_grant", {gate_open, grant_out, full_deny}, 0);
      req_out = 1'b0;
      occupancy = 3'd6; req_in = 1'b1;
      push_exp(1, 0);
      tick();
      check_eq("t4_cap_minus1_grant", grant_in, 1);
      occupancy = 3'd7;
      tick();
      check_eq("t4_open_no_deny", {full_deny, gate_open}, 2'b01);
      req_in = 1'b0;
      pulse_in_done();
      repeat (5) tick();

      // 5: timeout, then done on the terminal cycle
      occupancy = 3'd3; req_out = 1'b1;
      push_exp(0, 1);
      tick();
      req_out = 1'b0;
      repeat (19) begin
         tick();
         check_eq("t5_open_hold", {gate_open, timeout_p}, 2'b10);
      end
      tick();
      check_eq("t5_timeout_p", timeout_p, 1);
      check_eq("t5_timeout_close", {gate_open, grant_out}, 0);
      tick();
      check_eq("t5_timeout_1cyc", timeout_p, 0);
      repeat (5) tick();
      req_out = 1'b1;
      push_exp(0, 1);
      tick();
      req_out = 1'b0;
      repeat (19) tick();
      pulse_out_done();
      check_eq("t5_done_wins", {gate_open, timeout_p}, 0);
      check_eq("t5_no_err", proto_err, 0);
      repeat (5) tick();

      // 6: wrong-direction done, asynchronous close on reset
      req_out = 1'b1;
      push_exp(0, 1);
      tick();
      req_out = 1'b0;
      tick();
      pulse_in_done();
      check_eq("t6_proto_err", proto_err, 1);
      check_eq("t6_grant_kept", {gate_open, grant_out}, 2'b11);
      repeat (3) tick();
      check_eq("t6_err_sticky", proto_err, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t6_async_close", {gate_open, grant_out, proto_err}, 0);
      #3;
      rst_n = 1'b1;
      tick();
      pulse_out_done();
      check_eq("t6_idle_done_err", proto_err, 1);
      check_eq("t6_idle_no_gate", gate_open, 0);

      tick();
      check_eq("sb_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
